// File: rtl/obi_uart_bridge.sv
// rtl/obi_uart_bridge.sv - byte-stream command frames to single OBI manager transactions.
// Optional partial-frame timeout: define OBI_UART_BRIDGE_TIMEOUT_EN.

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module obi_uart_bridge #(
  parameter obi_pkg::obi_cfg_t ObiCfg        = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t     = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t     = obi_pkg::obi_rsp_t,
  parameter int unsigned       TimeoutCycles = 32'd1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output obi_req_t   obi_req_o,
  input  obi_rsp_t   obi_rsp_i,
  output logic       busy_o
);

  localparam logic [7:0] CmdWrite  = 8'h01;
  localparam logic [7:0] CmdRead   = 8'h02;
  localparam logic [7:0] StatusOk  = 8'hA5;
  localparam logic [7:0] StatusErr = 8'hEE;
  localparam logic [7:0] StatusUnk = 8'h3F;

  if (ObiCfg.AddrWidth != 32 || ObiCfg.DataWidth != 32 || TimeoutCycles == 0) begin : g_cfg_err
    $error("obi_uart_bridge: unsupported configuration");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    REQ,
    RSP,
    TX_STATUS,
    TX_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [7:0]  status_q, status_d;

  logic rx_fire;
  logic tx_fire;

  assign rx_ready_o = !rst_i && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_valid_o = (state_q == TX_STATUS) || (state_q == TX_DATA);
  assign tx_fire    = tx_valid_o && tx_ready_i;
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == TX_STATUS) begin
      tx_data_o = status_q;
    end else if (state_q == TX_DATA) begin
      tx_data_o = rdata_q[{cnt_q, 3'b000} +: 8];
    end
  end

  always_comb begin
    obi_req_o         = '0;
    obi_req_o.req     = (state_q == REQ);
    obi_req_o.rready  = (state_q == RSP);
    obi_req_o.a.addr  = addr_q;
    obi_req_o.a.we    = we_q && (state_q == REQ);
    obi_req_o.a.be    = 4'hF;
    obi_req_o.a.wdata = wdata_q;
    obi_req_o.a.aid   = '0;
  end

`ifdef OBI_UART_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_hit;

  always_comb begin
    tmo_d = '0;
    if ((state_q == ADDR || state_q == WDATA) && !rx_fire) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  assign tmo_hit = (state_q == ADDR || state_q == WDATA) && !rx_fire && (tmo_q == TimeoutCycles);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    status_d = status_q;

    unique case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          if (rx_data_i == CmdWrite) begin
            we_d    = 1'b1;
            state_d = ADDR;
          end else if (rx_data_i == CmdRead) begin
            we_d    = 1'b0;
            state_d = ADDR;
          end else begin
            we_d     = 1'b0;
            status_d = StatusUnk;
            state_d  = TX_STATUS;
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = we_q ? WDATA : REQ;
          end
        end
      end
      WDATA: begin
        if (rx_fire) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (obi_rsp_i.gnt) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (obi_rsp_i.rvalid) begin
          rdata_d  = obi_rsp_i.r.rdata;
          status_d = obi_rsp_i.r.err ? StatusErr : StatusOk;
          state_d  = TX_STATUS;
        end
      end
      TX_STATUS: begin
        if (tx_fire) begin
          cnt_d   = 2'd0;
          // Only a successful read carries data; errored read data is dropped.
          state_d = (!we_q && status_q == StatusOk) ? TX_DATA : IDLE;
        end
      end
      TX_DATA: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_obi_uart_bridge.sv
// tb/tb_obi_uart_bridge.sv - scoreboard bench for obi_uart_bridge.
// Timeout scenario follows OBI_UART_BRIDGE_TIMEOUT_EN like the design.

module tb_obi_uart_bridge;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;
  obi_pkg::obi_req_t obi_req;
  obi_pkg::obi_rsp_t obi_rsp = '0;

  always #5 clk = ~clk;

  obi_uart_bridge #(
    .TimeoutCycles(100)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp),
    .busy_o     (busy)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboards: {we, addr, wdata} per OBI request and bytes per tx transfer
  logic [64:0] exp_req_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] model_wdata = 32'h0;

  int          cfg_gnt_delay = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_err = 1'b0;
  int          tx_stall = 0;

  // OBI subordinate: grants after cfg_gnt_delay wait cycles, answers the cycle after gnt
  int                   wait_cnt = 0;
  bit                   rvalid_pend = 1'b0;
  bit                   a_held = 1'b0;
  obi_pkg::obi_a_chan_t a_prev;
  logic [64:0]          req_exp;

  always @(negedge clk) begin
    obi_rsp.gnt    = 1'b0;
    obi_rsp.rvalid = 1'b0;
    if (rst) begin
      wait_cnt    = 0;
      rvalid_pend = 1'b0;
      a_held      = 1'b0;
    end else begin
      if (rvalid_pend) begin
        check("rready", {71'h0, obi_req.rready}, 72'h1);
        obi_rsp.rvalid  = 1'b1;
        obi_rsp.r.rdata = cfg_rdata;
        obi_rsp.r.err   = cfg_err;
        rvalid_pend     = 1'b0;
      end
      if (obi_req.req) begin
        if (a_held) check("a_stable", {2'b0, obi_req.a}, {2'b0, a_prev});
        if (wait_cnt >= cfg_gnt_delay) begin
          obi_rsp.gnt = 1'b1;
          rvalid_pend = 1'b1;
          wait_cnt    = 0;
          a_held      = 1'b0;
          if (exp_req_q.size() == 0) begin
            check("unexpected_req", 72'h1, 72'h0);
          end else begin
            req_exp = exp_req_q.pop_front();
            check("obi_a",
                  {2'b0, obi_req.a.we, obi_req.a.be, obi_req.a.aid, obi_req.a.addr, obi_req.a.wdata},
                  {2'b0, req_exp[64], 4'hF, 1'b0, req_exp[63:32], req_exp[31:0]});
          end
        end else begin
          wait_cnt++;
          a_held = 1'b1;
          a_prev = obi_req.a;
        end
      end
    end
  end

  // Transmit sink with programmable stall per byte
  int         stall_cnt = 0;
  bit         hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always @(negedge clk) begin
    if (rst || !tx_valid) begin
      tx_ready  = 1'b0;
      stall_cnt = 0;
      hold_v    = 1'b0;
    end else begin
      check("rx_ready_during_tx", {71'h0, rx_ready}, 72'h0);
      if (hold_v) check("tx_stable", {64'h0, tx_data}, {64'h0, hold_d});
      if (stall_cnt < tx_stall) begin
        tx_ready  = 1'b0;
        stall_cnt++;
        hold_v    = 1'b1;
        hold_d    = tx_data;
      end else begin
        tx_ready  = 1'b1;
        stall_cnt = 0;
        hold_v    = 1'b0;
        if (exp_tx_q.size() == 0) check("unexpected_tx", {64'h0, tx_data}, 72'h100);
        else check("tx_byte", {64'h0, tx_data}, {64'h0, exp_tx_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 72'h0, 72'h1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic write_frame(input logic [31:0] addr, input logic [31:0] data, input int delay);
    cfg_gnt_delay = delay;
    cfg_err       = 1'b0;
    model_wdata   = data;
    exp_req_q.push_back({1'b1, addr, data});
    exp_tx_q.push_back(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic read_frame(input logic [31:0] addr, input logic [31:0] rdata, input logic err,
                            input int delay);
    cfg_gnt_delay = delay;
    cfg_err       = err;
    cfg_rdata     = rdata;
    exp_req_q.push_back({1'b0, addr, model_wdata});
    if (err) begin
      exp_tx_q.push_back(8'hEE);
    end else begin
      exp_tx_q.push_back(8'hA5);
      for (int i = 0; i < 4; i++) exp_tx_q.push_back(rdata[8*i +: 8]);
    end
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_tx_q.size() != 0 || exp_req_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {69'h0, busy, exp_tx_q.size() != 0, exp_req_q.size() != 0}, 72'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", {71'h0, busy}, 72'h0);
    check("rst_outputs", {68'h0, tx_valid, obi_req.req, obi_req.rready, rx_ready}, 72'h0);
    rst         = 1'b0;
    model_wdata = 32'h0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ctrl", {67'h0, busy, tx_valid, obi_req.req, obi_req.rready, obi_req.a.we}, 72'h0);
    check("reset_rx_ready", {71'h0, rx_ready}, 72'h0);
    check("reset_tx_data", {64'h0, tx_data}, 72'h0);
    rst = 1'b0;
    #1;
    check("idle_rx_ready", {71'h0, rx_ready}, 72'h1);

    write_frame(32'h8000_0010, 32'hDEAD_BEEF, 0);
    wait_idle("write_done");

    read_frame(32'h8000_0004, 32'h1234_5678, 1'b0, 3);
    wait_idle("read_done");

    read_frame(32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1);
    wait_idle("err_read_done");
    write_frame(32'h0000_0100, 32'h1122_3344, 2);
    wait_idle("after_err_write");
    read_frame(32'h0000_0100, 32'h1122_3344, 1'b0, 0);
    wait_idle("after_err_read");

    tx_stall = 5;
    read_frame(32'h0000_0040, 32'hA1B2_C3D4, 1'b0, 0);
    wait_idle("backpressure_read");
    write_frame(32'h0000_0044, 32'h0F0E_0D0C, 0);
    wait_idle("backpressure_write");
    tx_stall = 0;

    exp_tx_q.push_back(8'h3F);
    send_byte(8'h7E);
    wait_idle("unknown_cmd");
    write_frame(32'h0000_0003, 32'h55AA_55AA, 0);
    wait_idle("after_unknown_write");

    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h00);
    reset_dut();
    read_frame(32'h8000_0004, 32'h0BAD_CAFE, 1'b0, 0);
    wait_idle("after_reset_read");

    send_byte(8'h01);
    send_byte(8'h11);
    repeat (50) @(negedge clk);
    check("partial_frame_busy", {71'h0, busy}, 72'h1);
    repeat (60) @(negedge clk);
`ifdef OBI_UART_BRIDGE_TIMEOUT_EN
    check("timeout_idle", {71'h0, busy}, 72'h0);
    check("timeout_no_tx", {71'h0, exp_tx_q.size() != 0}, 72'h0);
    write_frame(32'h0000_0200, 32'h0102_0304, 0);
    wait_idle("after_timeout_write");
`else
    check("no_timeout_waits", {71'h0, busy}, 72'h1);
    reset_dut();
    write_frame(32'h0000_0200, 32'h0102_0304, 0);
    wait_idle("after_partial_write");
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
